// File: rtl/alu_issue_unit_pkg.sv
// alu_issue_unit_pkg
// Shared definitions for the ALU issue unit and the ALU it drives:
//   - ALU opcode encodings (ALUOp)
//   - issue FSM state encoding
//   - instruction word layout and register index width
package alu_issue_unit_pkg;

  typedef enum logic [2:0] {
    ALU_MOV  = 3'b000,
    ALU_NOT  = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } issue_state_e;

  localparam int INSTR_W   = 12;
  localparam int REG_IDX_W = 3;

  localparam int OP_MSB = 11;
  localparam int OP_LSB = 9;
  localparam int RD_MSB = 8;
  localparam int RD_LSB = 6;
  localparam int RS_MSB = 5;
  localparam int RS_LSB = 3;
  localparam int RT_MSB = 2;
  localparam int RT_LSB = 0;

endpackage

// File: rtl/alu_issue_unit_regs.sv
// issue_regs
// Architectural register array for the issue unit: two operand read ports,
// one write port and a debug read port. Register 0 always reads as zero and
// ignores writes. All read ports are combinational.
// Ports:
//   clk, rst                   clock, async active-high reset (clears all regs)
//   i_we, i_waddr, i_wdata     write port
//   i_raddr_a / o_rdata_a      operand A read port
//   i_raddr_b / o_rdata_b      operand B read port
//   i_raddr_dbg / o_rdata_dbg  debug read port
module issue_regs
  import alu_issue_unit_pkg::*;
#(
  parameter int N    = 32,
  parameter int REGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [N-1:0]         i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  output logic [N-1:0]         o_rdata_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  output logic [N-1:0]         o_rdata_b,
  input  logic [REG_IDX_W-1:0] i_raddr_dbg,
  output logic [N-1:0]         o_rdata_dbg
);

  logic [N-1:0] r_mem [0:REGS-1];

  logic w_wr_ok;
  assign w_wr_ok = i_we && (i_waddr != '0) && (int'(i_waddr) < REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // r0 and out-of-range indices read as zero regardless of array contents
  assign o_rdata_a   = ((i_raddr_a   == '0) || (int'(i_raddr_a)   >= REGS)) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b   = ((i_raddr_b   == '0) || (int'(i_raddr_b)   >= REGS)) ? '0 : r_mem[i_raddr_b];
  assign o_rdata_dbg = ((i_raddr_dbg == '0) || (int'(i_raddr_dbg) >= REGS)) ? '0 : r_mem[i_raddr_dbg];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Accepts one 12-bit instruction at a time, presents its operands and opcode
// to an external registered ALU, waits for the ALU output register, then
// writes the result back into the register array and latches the flags.
//
// state | meaning
// IDLE  | ready for a new instruction; operand outputs hold last issue
// ISSUE | operands/opcode presented to the ALU
// WAIT  | ALU output register captures the result
// WB    | result written to reg[rd], flags latched, done high
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   instr_valid, instr, instr_ready instruction handshake ({op,rd,rs,rt})
//   R2, R3, ALUOp                  operand A/B and opcode to the ALU
//   R1, overflow, zero, carry      registered ALU result and flags
//   done                           one-cycle pulse during writeback
//   flags                          {overflow,zero,carry} from last writeback
//   dbg_sel, dbg_data              combinational register read
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int n    = 32,
  parameter int REGS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [n-1:0]       R2,
  output logic [n-1:0]       R3,
  output logic [2:0]         ALUOp,
  input  logic [n-1:0]       R1,
  input  logic               overflow,
  input  logic               zero,
  input  logic               carry,
  output logic               done,
  output logic [2:0]         flags,
  input  logic [2:0]         dbg_sel,
  output logic [n-1:0]       dbg_data
);

  issue_state_e         r_state;
  logic                 r_ready;
  logic                 r_done;
  logic [REG_IDX_W-1:0] r_rd;
  logic [n-1:0]         r_r2;
  logic [n-1:0]         r_r3;
  logic [2:0]           r_aluop;
  logic [2:0]           r_flags;

  logic [n-1:0] w_rs_data;
  logic [n-1:0] w_rt_data;
  logic         w_we;

  // Operands are read straight from the incoming word and registered on the
  // accepting edge, so rd==rs/rt naturally sees pre-writeback values.
  issue_regs #(
    .N    (n),
    .REGS (REGS)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_we),
    .i_waddr     (r_rd),
    .i_wdata     (R1),
    .i_raddr_a   (instr[RS_MSB:RS_LSB]),
    .o_rdata_a   (w_rs_data),
    .i_raddr_b   (instr[RT_MSB:RT_LSB]),
    .o_rdata_b   (w_rt_data),
    .i_raddr_dbg (dbg_sel),
    .o_rdata_dbg (dbg_data)
  );

  assign w_we = (r_state == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_rd    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_aluop <= ALU_MOV;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid && r_ready) begin
            r_rd    <= instr[RD_MSB:RD_LSB];
            r_aluop <= instr[OP_MSB:OP_LSB];
            r_r2    <= w_rs_data;
            r_r3    <= w_rt_data;
            r_ready <= 1'b0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_done  <= 1'b1;
          r_state <= S_WB;
        end
        S_WB: begin
          r_done  <= 1'b0;
          r_flags <= {overflow, zero, carry};
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign done        = r_done;
  assign R2          = r_r2;
  assign R3          = r_r3;
  assign ALUOp       = r_aluop;
  assign flags       = r_flags;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
  import alu_issue_unit_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic [11:0]  instr;
  logic         instr_ready;
  logic [N-1:0] R1, R2, R3;
  logic [2:0]   ALUOp;
  logic         overflow, zero, carry;
  logic         done;
  logic [2:0]   flags;
  logic [2:0]   dbg_sel;
  logic [N-1:0] dbg_data;

  logic         alu_force;
  logic [N-1:0] alu_force_val;
  logic [N+2:0] alu_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.n(N), .REGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .R2          (R2),
    .R3          (R3),
    .ALUOp       (ALUOp),
    .R1          (R1),
    .overflow    (overflow),
    .zero        (zero),
    .carry       (carry),
    .done        (done),
    .flags       (flags),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // Registered ALU in front of the unit; alu_force lets the bench preload
  // registers through the normal writeback path.
  function automatic logic [N+2:0] alu_f(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   t;
    logic [N-1:0] s;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    t = '0;
    case (op)
      3'b000: s = a;
      3'b001: s = ~a;
      3'b010: begin
        t = {1'b0, a} + {1'b0, b};
        s = t[N-1:0];
        c = t[N];
        v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
      end
      3'b011: s = ~(a | b);
      3'b100: begin
        t = {1'b0, a} + {1'b0, ~b} + 1;
        s = t[N-1:0];
        c = t[N];
        v = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
      end
      3'b101: s = ~(a & b);
      3'b110: s = ($signed(a) < $signed(b)) ? 1 : 0;
      default: s = a & b;
    endcase
    return {v, (s == '0), c, s};
  endfunction

  always_comb alu_w = alu_f(ALUOp, R2, R3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R1 <= '0; overflow <= 1'b0; zero <= 1'b0; carry <= 1'b0;
    end else if (alu_force) begin
      R1 <= alu_force_val; overflow <= 1'b0; zero <= 1'b0; carry <= 1'b0;
    end else begin
      {overflow, zero, carry, R1} <= alu_w;
    end
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input logic [2:0] sel, input logic [N-1:0] exp, input string tag);
    dbg_sel = sel;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Issue one instruction, check done lands exactly in the 3rd cycle after
  // the accepting edge, and return at the negedge of the cycle after WB.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    instr = {op, rd, rs, rt};
    instr_valid = 1'b1;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, N'(instr_ready), N'(1));
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check({tag, "_done"}, N'(done), N'(i == 3));
    end
    @(negedge clk);
  endtask

  task automatic load_reg(input logic [2:0] rd, input logic [N-1:0] val);
    alu_force = 1'b1;
    alu_force_val = val;
    run_instr(ALU_MOV, rd, 3'd0, 3'd0, "load");
    alu_force = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] prog [3];
    int acc_cnt, done_cnt, low_cnt, idx, dcnt;
    int acc_cyc [3];
    int done_cyc [3];
    bit acc_now;

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_sel = '0;
    alu_force = 1'b0;
    alu_force_val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ready", N'(instr_ready), N'(1));
    check("rst_done",  N'(done), N'(0));
    check("rst_R2",    R2, '0);
    check("rst_R3",    R3, '0);
    check("rst_aluop", N'(ALUOp), N'(0));
    check("rst_flags", N'(flags), N'(0));
    for (int i = 0; i < 8; i++) chk_reg(3'(i), '0, "rst_reg");

    // ADD r1 = r0 + r0
    run_instr(ALU_ADD, 3'd1, 3'd0, 3'd0, "add0");
    chk_reg(3'd1, '0, "add0_reg1");
    check("add0_flags", N'(flags), N'(3'b010));

    // carry-out: -1 + -1
    load_reg(3'd2, 32'hFFFF_FFFF);
    load_reg(3'd3, 32'hFFFF_FFFF);
    run_instr(ALU_ADD, 3'd4, 3'd2, 3'd3, "addc");
    chk_reg(3'd4, 32'hFFFF_FFFE, "addc_reg4");
    check("addc_flags", N'(flags), N'(3'b001));
    check("idle_R2",    R2, 32'hFFFF_FFFF);
    check("idle_R3",    R3, 32'hFFFF_FFFF);
    check("idle_aluop", N'(ALUOp), N'(3'b010));

    // back-to-back with instr_valid held high
    prog[0] = {ALU_ADD, 3'd5, 3'd4, 3'd0};
    prog[1] = {ALU_NOT, 3'd7, 3'd5, 3'd0};
    prog[2] = {ALU_ADD, 3'd7, 3'd7, 3'd7};
    acc_cnt = 0; done_cnt = 0; low_cnt = 0; idx = 0;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = 0; done_cyc[i] = 0; end
    @(negedge clk);
    instr = prog[0];
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      acc_now = 1'b0;
      if (done) begin
        if (done_cnt < 3) done_cyc[done_cnt] = cyc;
        done_cnt++;
      end
      if (!instr_ready) low_cnt++;
      if (instr_ready && instr_valid) begin
        if (acc_cnt < 3) acc_cyc[acc_cnt] = cyc;
        acc_cnt++;
        acc_now = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 3) instr = prog[idx];
        else instr_valid = 1'b0;
      end
    end
    check("b2b_accepts",  N'(acc_cnt), N'(3));
    check("b2b_dones",    N'(done_cnt), N'(3));
    check("b2b_ready_lo", N'(low_cnt), N'(9));
    check("b2b_lat",      N'(done_cyc[0] - acc_cyc[0]), N'(3));
    check("b2b_gap1",     N'(done_cyc[1] - done_cyc[0]), N'(4));
    check("b2b_gap2",     N'(done_cyc[2] - done_cyc[1]), N'(4));
    chk_reg(3'd5, 32'hFFFF_FFFE, "b2b_reg5");
    chk_reg(3'd7, 32'd2, "b2b_reg7");

    // SUB with rd==rs==rt
    load_reg(3'd5, 32'd1000);
    run_instr(ALU_SUB, 3'd5, 3'd5, 3'd5, "sub");
    chk_reg(3'd5, '0, "sub_reg5");
    check("sub_zero",  N'(flags[1]), N'(1));
    check("sub_flags", N'(flags), N'(3'b011));

    // MOV into r0 is discarded
    load_reg(3'd1, 32'd421);
    run_instr(ALU_MOV, 3'd0, 3'd1, 3'd0, "mov0");
    check("mov0_R2", R2, 32'd421);
    chk_reg(3'd0, '0, "mov0_reg0");
    check("mov0_flags", N'(flags), N'(3'b000));

    // reset during WAIT aborts the instruction
    @(negedge clk);
    instr = {ALU_ADD, 3'd6, 3'd1, 3'd1};
    instr_valid = 1'b1;
    check("abort_ready", N'(instr_ready), N'(1));
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_wait_done", N'(done), N'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", N'(dcnt), N'(0));
    check("abort_ready2",  N'(instr_ready), N'(1));
    check("abort_aluop",   N'(ALUOp), N'(0));
    chk_reg(3'd6, '0, "abort_reg6");

    // unit accepts work again after the abort
    load_reg(3'd2, 32'd7);
    run_instr(ALU_ADD, 3'd6, 3'd2, 3'd2, "post");
    chk_reg(3'd6, 32'd14, "post_reg6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
